// File: rtl/frogger_defs.sv
// Shared Frogger definitions: game-state codes, bitmap tile codes and score cap.
// Used by frogger_state_ctrl and frogger_game.
package frogger_defs;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_P1_WINS = 2'b10;
    localparam logic [1:0] ST_CLEANUP = 2'b11;

    localparam logic [3:0] TILE_WALL  = 4'd0;
    localparam logic [3:0] TILE_ROAD  = 4'd1;
    localparam logic [3:0] TILE_WATER = 4'd2;
    localparam logic [3:0] TILE_SAFE  = 4'd3;
    localparam logic [3:0] TILE_LILY  = 4'd4;

    localparam logic [6:0] SCORE_MAX  = 7'd99;

    function automatic logic [6:0] score_inc(input logic [6:0] score);
        return (score >= SCORE_MAX) ? SCORE_MAX : score + 7'd1;
    endfunction

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for a synchronous button level; history resets to 1 so a
// button held through reset never reports an edge.
module button_edge (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Level,
    output logic o_Rise
);

    logic level_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= i_Level;
        end
    end

    assign o_Rise = i_Level & ~level_q;

endmodule

// File: rtl/frogger_state_ctrl.sv
// Frogger game-state controller: start/lose-life/score/win sequencing with a
// frame-counted pause between lives. All outputs are registered.
module frogger_state_ctrl
    import frogger_defs::*;
#(
    parameter int c_MAX_LIVES    = 3,
    parameter int c_WIN_SCORE    = 5,
    parameter int c_GOAL_ROW     = 0,
    parameter int c_PAUSE_FRAMES = 30
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Game_Start,
    input  logic       i_Frame_Tick,
    input  logic       i_Collided,
    input  logic       i_On_Log,
    input  logic [5:0] i_Frogger_Y,
    input  logic [3:0] i_Tile_Type,
    output logic [1:0] o_State,
    output logic       o_Game_Active,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic       o_Respawn,
    output logic       o_Game_Over
);

    localparam int CNT_W = $clog2(c_PAUSE_FRAMES + 1);

    localparam logic [1:0]       LIVES_INIT = 2'(c_MAX_LIVES);
    localparam logic [6:0]       WIN_SCORE  = 7'(c_WIN_SCORE);
    localparam logic [5:0]       GOAL_ROW   = 6'(c_GOAL_ROW);
    localparam logic [CNT_W-1:0] PAUSE_END  = CNT_W'(c_PAUSE_FRAMES);

    logic [1:0]       state_q,     state_nxt;
    logic             active_q,    active_nxt;
    logic [1:0]       lives_q,     lives_nxt;
    logic [6:0]       score_q,     score_nxt;
    logic             respawn_q,   respawn_nxt;
    logic             game_over_q, game_over_nxt;
    logic [CNT_W-1:0] pause_q,     pause_nxt;

    logic             start_rise;
    logic             hazard;
    logic             goal;
    logic [6:0]       score_up;
    logic [CNT_W-1:0] pause_up;

    button_edge u_start_edge (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Level (i_Game_Start),
        .o_Rise  (start_rise)
    );

    // Event qualifiers; they only take effect in RUNNING, the FSM enforces that.
    assign hazard   = i_Collided | ((i_Tile_Type == TILE_WATER) & ~i_On_Log);
    assign goal     = (i_Frogger_Y == GOAL_ROW) & (i_Tile_Type == TILE_LILY);
    assign score_up = score_inc(score_q);
    assign pause_up = pause_q + CNT_W'(1);

    always_comb begin
        state_nxt     = state_q;
        lives_nxt     = lives_q;
        score_nxt     = score_q;
        respawn_nxt   = 1'b0;
        game_over_nxt = game_over_q;
        pause_nxt     = pause_q;

        case (state_q)
            ST_IDLE, ST_P1_WINS: begin
                if (start_rise) begin
                    state_nxt     = ST_RUNNING;
                    lives_nxt     = LIVES_INIT;
                    score_nxt     = 7'd0;
                    game_over_nxt = 1'b0;
                    respawn_nxt   = 1'b1;
                end
            end

            ST_RUNNING: begin
                // A hazard outranks a simultaneous goal: the life is lost, no point scored.
                if (hazard) begin
                    state_nxt = ST_CLEANUP;
                    lives_nxt = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    pause_nxt = '0;
                end else if (goal) begin
                    score_nxt = score_up;
                    pause_nxt = '0;
                    state_nxt = (score_up == WIN_SCORE) ? ST_P1_WINS : ST_CLEANUP;
                end
            end

            ST_CLEANUP: begin
                if (i_Frame_Tick) begin
                    pause_nxt = pause_up;
                    if (pause_up == PAUSE_END) begin
                        if (lives_q != 2'd0) begin
                            state_nxt   = ST_RUNNING;
                            respawn_nxt = 1'b1;
                        end else begin
                            state_nxt     = ST_IDLE;
                            game_over_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        active_nxt = (state_nxt == ST_RUNNING);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
            lives_q     <= LIVES_INIT;
            score_q     <= 7'd0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            pause_q     <= '0;
        end else begin
            state_q     <= state_nxt;
            active_q    <= active_nxt;
            lives_q     <= lives_nxt;
            score_q     <= score_nxt;
            respawn_q   <= respawn_nxt;
            game_over_q <= game_over_nxt;
            pause_q     <= pause_nxt;
        end
    end

    assign o_State       = state_q;
    assign o_Game_Active = active_q;
    assign o_Lives       = lives_q;
    assign o_Score       = score_q;
    assign o_Respawn     = respawn_q;
    assign o_Game_Over   = game_over_q;

endmodule

// File: tb/tb_frogger_state_ctrl.sv
// Scoreboard bench for frogger_state_ctrl: directed game scenarios followed by
// randomized play, checked cycle by cycle against a behavioural game model.
module tb_frogger_state_ctrl;

    localparam int MAX_LIVES = 3;
    localparam int WIN_SCORE = 5;
    localparam int GOAL_ROW  = 0;
    localparam int PAUSE     = 30;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_WIN   = 2;
    localparam int M_CLEAN = 3;

    logic       clk = 1'b0;
    logic       i_Rst;
    logic       i_Game_Start;
    logic       i_Frame_Tick;
    logic       i_Collided;
    logic       i_On_Log;
    logic [5:0] i_Frogger_Y;
    logic [3:0] i_Tile_Type;
    logic [1:0] o_State;
    logic       o_Game_Active;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic       o_Respawn;
    logic       o_Game_Over;

    logic [13:0] dut_vec;
    logic [13:0] exp_q[$];
    logic [13:0] mon_exp;

    int vectors     = 0;
    int compares    = 0;
    int miscompares = 0;
    bit rst_req;

    // Game model state
    int m_mode;
    int m_lives;
    int m_score;
    int m_ticks;
    bit m_resp;
    bit m_gover;
    bit m_prev_start;

    always #5 clk = ~clk;

    frogger_state_ctrl #(
        .c_MAX_LIVES    (MAX_LIVES),
        .c_WIN_SCORE    (WIN_SCORE),
        .c_GOAL_ROW     (GOAL_ROW),
        .c_PAUSE_FRAMES (PAUSE)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (i_Rst),
        .i_Game_Start  (i_Game_Start),
        .i_Frame_Tick  (i_Frame_Tick),
        .i_Collided    (i_Collided),
        .i_On_Log      (i_On_Log),
        .i_Frogger_Y   (i_Frogger_Y),
        .i_Tile_Type   (i_Tile_Type),
        .o_State       (o_State),
        .o_Game_Active (o_Game_Active),
        .o_Lives       (o_Lives),
        .o_Score       (o_Score),
        .o_Respawn     (o_Respawn),
        .o_Game_Over   (o_Game_Over)
    );

    assign dut_vec = {o_State, o_Game_Active, o_Lives, o_Score, o_Respawn, o_Game_Over};

    function automatic logic [13:0] pk(input int st, input bit act, input int lives,
                                       input int score, input bit resp, input bit go);
        return {2'(st), act, 2'(lives), 7'(score), resp, go};
    endfunction

    function automatic logic [13:0] model_vec();
        return pk(m_mode, m_mode == M_RUN, m_lives, m_score, m_resp, m_gover);
    endfunction

    function automatic void model_reset();
        m_mode       = M_IDLE;
        m_lives      = MAX_LIVES;
        m_score      = 0;
        m_ticks      = 0;
        m_resp       = 1'b0;
        m_gover      = 1'b0;
        m_prev_start = 1'b1;
    endfunction

    // Game rules as seen by the player, one clock at a time.
    function automatic void model_step(input bit st, input bit tk, input bit co,
                                       input bit ol, input int y, input int tt);
        bit pressed;
        bit drowned;
        bit scored;
        if (rst_req) begin
            model_reset();
            return;
        end
        pressed      = st && !m_prev_start;
        m_prev_start = st;
        m_resp       = 1'b0;
        drowned      = co || (tt == 2 && !ol);
        scored       = (y == GOAL_ROW) && (tt == 4);
        if (m_mode == M_RUN) begin
            if (drowned) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_mode  = M_CLEAN;
                m_ticks = 0;
            end else if (scored) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
                m_mode  = (m_score == WIN_SCORE) ? M_WIN : M_CLEAN;
                m_ticks = 0;
            end
        end else if (m_mode == M_CLEAN) begin
            if (tk) begin
                m_ticks++;
                if (m_ticks == PAUSE) begin
                    if (m_lives > 0) begin
                        m_mode = M_RUN;
                        m_resp = 1'b1;
                    end else begin
                        m_mode  = M_IDLE;
                        m_gover = 1'b1;
                    end
                end
            end
        end else if (pressed) begin
            m_mode  = M_RUN;
            m_lives = MAX_LIVES;
            m_score = 0;
            m_gover = 1'b0;
            m_resp  = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got state=%0d active=%0d lives=%0d score=%0d respawn=%0d game_over=%0d, expected state=%0d active=%0d lives=%0d score=%0d respawn=%0d game_over=%0d",
                     name, $time, got[13:12], got[11], got[10:9], got[8:2], got[1], got[0],
                     exp[13:12], exp[11], exp[10:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: every active edge presents a new output vector.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            compares++;
            check("cycle", dut_vec, mon_exp);
        end
    end

    task automatic drive(input bit st, input bit tk, input bit co, input bit ol,
                         input int y, input int tt);
        @(negedge clk);
        i_Rst        = rst_req;
        i_Game_Start = st;
        i_Frame_Tick = tk;
        i_Collided   = co;
        i_On_Log     = ol;
        i_Frogger_Y  = 6'(y);
        i_Tile_Type  = 4'(tt);
        model_step(st, tk, co, ol, y, tt);
        exp_q.push_back(model_vec());
        vectors++;
    endtask

    task automatic spot(input string name, input logic [13:0] exp);
        @(posedge clk);
        #2;
        compares++;
        check(name, dut_vec, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 10, 3);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 10, 3);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 10, 3);
        end
    endtask

    task automatic press();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10, 3);
    endtask

    task automatic drown();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 20, 2);
    endtask

    task automatic goal();
        drive(1'b0, 1'b0, 1'b0, 1'b0, GOAL_ROW, 4);
    endtask

    task automatic do_reset(input int n, input bit hold);
        @(negedge clk);
        #2;
        rst_req      = 1'b1;
        i_Rst        = 1'b1;
        i_Game_Start = hold;
        model_reset();
        #1;
        compares++;
        check("reset_async", dut_vec, model_vec());
        exp_q.push_back(model_vec());
        repeat (n) drive(hold, 1'b0, 1'b0, 1'b0, 10, 3);
        rst_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        i_Rst        = 1'b1;
        rst_req      = 1'b1;
        i_Game_Start = 1'b0;
        i_Frame_Tick = 1'b0;
        i_Collided   = 1'b0;
        i_On_Log     = 1'b0;
        i_Frogger_Y  = 6'd10;
        i_Tile_Type  = 4'd3;
        model_reset();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 10, 3);
        rst_req = 1'b0;
        idle(2);
        spot("reset_state", pk(M_IDLE, 0, 3, 0, 0, 0));

        press();
        spot("start_game", pk(M_RUN, 1, 3, 0, 1, 0));
        idle(2);

        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b0, 10, 1);
        spot("collide_once", pk(M_CLEAN, 0, 2, 0, 0, 0));
        ticks(PAUSE);
        spot("respawn_after_pause", pk(M_RUN, 1, 2, 0, 1, 0));
        idle(1);

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 20, 2);
        spot("log_keeps_frog", pk(M_RUN, 1, 2, 0, 0, 0));

        drown();
        ticks(PAUSE);
        idle(2);
        drown();
        ticks(PAUSE);
        spot("first_game_over", pk(M_IDLE, 0, 0, 0, 0, 1));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 10, 3);
        spot("restart_held", pk(M_RUN, 1, 3, 0, 1, 0));
        repeat (99) drive(1'b1, 1'b0, 1'b0, 1'b0, 10, 3);
        spot("held_no_second_start", pk(M_RUN, 1, 3, 0, 0, 0));
        idle(1);

        repeat (3) begin
            drown();
            ticks(PAUSE);
            idle(1);
        end
        spot("three_drowns", pk(M_IDLE, 0, 0, 0, 0, 1));

        press();
        idle(1);
        for (int k = 0; k < WIN_SCORE; k++) begin
            goal();
            if (k < WIN_SCORE - 1) begin
                ticks(PAUSE);
                idle(1);
            end
        end
        spot("five_goals_win", pk(M_WIN, 0, 3, 5, 0, 0));
        goal();
        spot("win_ignores_goal", pk(M_WIN, 0, 3, 5, 0, 0));

        press();
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, GOAL_ROW, 4);
        spot("hazard_beats_goal", pk(M_CLEAN, 0, 2, 0, 0, 0));

        ticks(15);
        do_reset(3, 1'b0);
        idle(3);
        spot("abort_mid_cleanup", pk(M_IDLE, 0, 3, 0, 0, 0));

        do_reset(2, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 10, 3);
        spot("held_through_reset", pk(M_IDLE, 0, 3, 0, 0, 0));
        idle(2);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end else begin
                automatic bit st = ($urandom_range(0, 15) == 0);
                automatic bit tk = 1'($urandom_range(0, 1));
                automatic bit co = ($urandom_range(0, 29) == 0);
                automatic bit ol = 1'($urandom_range(0, 1));
                automatic int y  = ($urandom_range(0, 2) == 0) ? GOAL_ROW : int'($urandom_range(0, 63));
                automatic int tt = int'($urandom_range(0, 4));
                drive(st, tk, co, ol, y, tt);
            end
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
